// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: load-use bubbles, data-memory freeze,
// redirect flush sequencing and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              id_redirect,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              pipe_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                REM_W    = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0]  REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LU_STALL,
        S_MEM_WAIT
    } state_t;

    state_t            r_state;
    state_t            r_saved;
    logic [REM_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    state_t            w_next_state;
    state_t            w_next_saved;
    state_t            w_eff_state;
    logic [REM_W-1:0]  w_next_rem;
    logic              w_lu;
    logic              w_pc;
    logic              w_ifid;
    logic              w_pipe;
    logic              w_bubble;
    logic              w_fl_ifid;
    logic              w_fl_idex;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign w_lu = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

    // A memory freeze parks the interrupted state; it is resumed once mem_busy drops
    assign w_eff_state = (r_state == S_MEM_WAIT) ? r_saved : r_state;

    always_comb begin
        w_next_state = r_state;
        w_next_saved = r_saved;
        w_next_rem   = r_rem;
        w_pc         = 1'b1;
        w_ifid       = 1'b1;
        w_pipe       = 1'b1;
        w_bubble     = 1'b0;
        w_fl_ifid    = 1'b0;
        w_fl_idex    = 1'b0;

        if (mem_busy) begin
            w_pc         = 1'b0;
            w_ifid       = 1'b0;
            w_pipe       = 1'b0;
            w_next_state = S_MEM_WAIT;
            w_next_saved = w_eff_state;
        end else if (ex_redirect) begin
            w_fl_ifid    = 1'b1;
            w_fl_idex    = 1'b1;
            w_next_state = S_IDLE;
            w_next_rem   = '0;
        end else if (w_eff_state == S_LU_STALL) begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_bubble = 1'b1;
            if (r_rem <= REM_ONE) begin
                w_next_state = S_IDLE;
                w_next_rem   = '0;
            end else begin
                w_next_state = S_LU_STALL;
                w_next_rem   = r_rem - REM_ONE;
            end
        end else if (w_lu) begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                w_next_state = S_LU_STALL;
                w_next_rem   = REM_INIT;
            end else begin
                w_next_state = S_IDLE;
                w_next_rem   = '0;
            end
        end else if (id_redirect) begin
            // Only reached when no load-use stall is pending, so ID operands are valid
            w_fl_ifid    = 1'b1;
            w_next_state = S_IDLE;
        end else begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_saved <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_saved <= w_next_saved;
            r_rem   <= w_next_rem;
        end
    end

    assign pc_write    = rst_n & w_pc;
    assign ifid_write  = rst_n & w_ifid;
    assign pipe_write  = rst_n & w_pipe;
    assign idex_bubble = rst_n & w_bubble;
    assign flush_ifid  = rst_n & w_fl_ifid;
    assign flush_idex  = rst_n & w_fl_idex;

    // Clear wins over increment; counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (flush_ifid) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
